kronos_id: RTL and testbench
============================

Name: kronos_id

Overview:
- Kronos RV32I instruction decode stage. Sits directly downstream of the fetch stage and consumes its IF/ID pipe (pc, ir, valid/ready).
- Decodes the instruction, reads the 32x32 register file, forms operands and immediates, and interlocks on RAW hazards using a write-pending scoreboard.
- Produces the registered ID/EX pipe struct for execute, and owns the register-file write port used by writeback.

Parameters:
- None. The register count is fixed at 32 by RV32I.

Ports:
- clk  in  1  clock
- rstz  in  1  reset, asynchronous, active-low
- fetch  in  pipeIFID_t (64)  {pc[31:0], ir[31:0]} from fetch
- pipe_in_vld  in  1  fetch payload valid
- pipe_in_rdy  out  1  decode accepts fetch payload this cycle
- decode  out  pipeIDEX_t  registered decode payload to execute
- pipe_out_vld  out  1  decode payload valid
- pipe_out_rdy  in  1  execute accepts decode payload
- regwr_data  in  32  writeback data
- regwr_sel  in  5  writeback register index
- regwr_en  in  1  writeback strobe
- branch  in  1  flush: redirect taken in execute

Behaviour:
- Reset: pipe_out_vld=0; scoreboard=0; all register-file entries=0. The decode payload is don't-care while invalid.
- Transfer rules:
  - Input transfer = pipe_in_vld & pipe_in_rdy.
  - Output transfer = pipe_out_vld & pipe_out_rdy.
- pipe_in_rdy = ~stall & ~branch & (~pipe_out_vld | pipe_out_rdy).
- Latency: 1 cycle. An input transfer in cycle N gives pipe_out_vld=1 with the decode payload in cycle N+1.
- pipe_out_vld holds until output transfer. It clears on output transfer with no new input transfer.
- Decode fields:
  - pc, ir, rd, rs1, rs2.
  - imm: sign-extended I/S/B/U/J per opcode.
  - op1: rs1 data; pc for AUIPC/JAL/JALR; 0 for LUI.
  - op2: imm, or rs2 data for OP/BRANCH.
  - rs2_data (store data / branch compare).
  - aluop[3:0]: funct3 plus the funct7[5] bit.
  - Flags: regwr, is_load, is_store, is_branch, is_jump, is_system, illegal.
- regwr=0 when rd==x0. Any unrecognised opcode sets illegal=1 and forces regwr=0.
- Register file:
  - Flop-based, 2 combinational read ports, 1 write port; x0 always reads 0.
  - Writes to x0 are ignored.
  - Write-through bypass: if regwr_en and regwr_sel==rs (rs!=0), the read returns regwr_data in the same cycle.
- Scoreboard (32 bits, bit 0 tied to 0):
  - Set bit rd on input transfer when regwr=1.
  - Clear bit regwr_sel on regwr_en.
  - If set and clear hit the same register in one cycle, set wins (a newer writer is in flight).
- stall = pipe_in_vld & ((rs1 used & sb[rs1] & ~(regwr_en & regwr_sel==rs1)) | (same for rs2)).
  - Unused sources (LUI/AUIPC/JAL, rs2 of I-type) never stall.
- Flush: branch=1 in a cycle has priority over everything.
  - The next cycle has pipe_out_vld=0, and no input transfer happens that cycle.
  - The scoreboard is not cleared, because already-issued instructions still write back.
- Reset mid-operation: all state returns to reset values asynchronously; pending scoreboard bits are discarded.

Decomposition:
- Shared package kronos_types:
  - pipeIDEX_t struct
  - opcode constants (OP, OPIMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM)
  - aluop encoding
- Sub-module kronos_RF: register file with write-through bypass, ports rs1/rs2/rd sel and data.
- The scoreboard and hazard logic stay in kronos_id.

Test Plan:
- Reset, then ADDI x1,x0,5 (ir=0x00500093, pc=0x0) -> next cycle pipe_out_vld=1, op1=0, op2=5, rd=1, regwr=1, aluop=ADD; sb[1]=1.
- Issue ADDI x1, then ADD x2,x1,x1 (0x00108133) with no writeback -> pipe_in_rdy=0 held. Then regwr_en=1, regwr_sel=1, data=5 -> ADD accepted in that same cycle with op1=op2=5.
- pipe_out_rdy=0 for 3 cycles while pipe_in_vld=1 -> the decode payload is stable and pipe_in_rdy=0. The first rdy=1 cycle transfers the held payload and accepts the next.
- branch=1 while pipe_out_vld=1 and pipe_in_vld=1 -> next cycle pipe_out_vld=0 and no input consumed; sb bits set earlier remain.
- LUI x5,0x12345 (0x123452B7) -> op1=0, op2=0x12345000; JAL x0 -> regwr=0, sb unchanged; ir=0xFFFFFFFF -> illegal=1, regwr=0.
- Write x0 with 0xDEADBEEF via writeback, then decode ADD x3,x0,x0 -> op1=op2=0 and no stall.

Source files
------------

// File: rtl/kronos_id_pkg.sv
// Shared Kronos types: IF/ID and ID/EX pipe payloads, RV32I opcodes, ALU op encoding
// and the immediate decoder used by the decode stage.
package kronos_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } pipeIFID_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] imm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  aluop;
    logic        regwr;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        is_system;
    logic        illegal;
  } pipeIDEX_t;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OPIMM    = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  // aluop = {funct7[5], funct3}
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  function automatic logic [31:0] decode_imm(input logic [31:0] ir);
    logic [31:0] imm;
    case (ir[6:0])
      OPIMM, LOAD, JALR, SYSTEM: imm = {{20{ir[31]}}, ir[31:20]};
      STORE:                     imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      BRANCH:                    imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      LUI, AUIPC:                imm = {ir[31:12], 12'b0};
      JAL:                       imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/kronos_id_if.sv
// Fetch-to-decode and decode-to-execute handshakes for the Kronos decode stage.
interface kronos_id_if;
  import kronos_types::*;

  pipeIFID_t fetch;
  logic      pipe_in_vld;
  logic      pipe_in_rdy;
  pipeIDEX_t decode;
  logic      pipe_out_vld;
  logic      pipe_out_rdy;

  modport master (
    output fetch, pipe_in_vld, pipe_out_rdy,
    input  pipe_in_rdy, decode, pipe_out_vld
  );

  modport slave (
    input  fetch, pipe_in_vld, pipe_out_rdy,
    output pipe_in_rdy, decode, pipe_out_vld
  );
endinterface

// File: rtl/kronos_id_rf.sv
// 32x32 flop register file, two combinational reads with write-through bypass, one write.
module kronos_RF (
  input  logic        clk,
  input  logic        rstz,
  input  logic [4:0]  rs1_sel,
  input  logic [4:0]  rs2_sel,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic [4:0]  rd_sel,
  input  logic [31:0] rd_data,
  input  logic        rd_en
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rd_en && rd_sel != 5'd0) begin
      regs[rd_sel] <= rd_data;
    end
  end

  // A writeback landing this cycle is visible to decode without waiting for the flop.
  always_comb begin
    rs1_data = regs[rs1_sel];
    if (rs1_sel == 5'd0) rs1_data = '0;
    else if (rd_en && rd_sel == rs1_sel) rs1_data = rd_data;

    rs2_data = regs[rs2_sel];
    if (rs2_sel == 5'd0) rs2_data = '0;
    else if (rd_en && rd_sel == rs2_sel) rs2_data = rd_data;
  end

endmodule

// File: rtl/kronos_id.sv
// Kronos RV32I decode stage: field decode, operand formation, register file and
// write-pending scoreboard interlock feeding a registered ID/EX pipe.
module kronos_id
  import kronos_types::*;
(
  input  logic        clk,
  input  logic        rstz,
  kronos_id_if.slave  pipe,
  input  logic [31:0] regwr_data,
  input  logic [4:0]  regwr_sel,
  input  logic        regwr_en,
  input  logic        branch
);

  logic [31:0] pc, ir;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_used, rs2_used, wr;
  logic        rs1_pend, rs2_pend, stall;
  logic        in_xfer, out_xfer;
  logic [31:0] sb, sb_next;
  logic        out_vld;
  pipeIDEX_t   dec, decode_q;

  assign pc     = pipe.fetch.pc;
  assign ir     = pipe.fetch.ir;
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  kronos_RF u_rf (
    .clk      (clk),
    .rstz     (rstz),
    .rs1_sel  (rs1),
    .rs2_sel  (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_sel   (regwr_sel),
    .rd_data  (regwr_data),
    .rd_en    (regwr_en)
  );

  always_comb begin
    dec          = '0;
    dec.pc       = pc;
    dec.ir       = ir;
    dec.rd       = rd;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.imm      = decode_imm(ir);
    dec.op1      = rs1_data;
    dec.op2      = decode_imm(ir);
    dec.rs2_data = rs2_data;
    dec.aluop    = ALU_ADD;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    wr           = 1'b0;
    case (ir[6:0])
      OP: begin
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        wr        = 1'b1;
        dec.op2   = rs2_data;
        dec.aluop = {ir[30], funct3};
      end
      OPIMM: begin
        rs1_used  = 1'b1;
        wr        = 1'b1;
        dec.aluop = {(funct3 == 3'b101) & ir[30], funct3};
      end
      LOAD: begin
        rs1_used    = 1'b1;
        wr          = 1'b1;
        dec.is_load = 1'b1;
      end
      STORE: begin
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
        dec.is_store = 1'b1;
      end
      BRANCH: begin
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        dec.is_branch = 1'b1;
        dec.op2       = rs2_data;
        dec.aluop     = {1'b0, funct3};
      end
      JAL: begin
        wr          = 1'b1;
        dec.is_jump = 1'b1;
        dec.op1     = pc;
      end
      JALR: begin
        rs1_used    = 1'b1;
        wr          = 1'b1;
        dec.is_jump = 1'b1;
        dec.op1     = pc;
      end
      LUI: begin
        wr      = 1'b1;
        dec.op1 = '0;
      end
      AUIPC: begin
        wr      = 1'b1;
        dec.op1 = pc;
      end
      SYSTEM: begin
        dec.is_system = 1'b1;
        wr            = (funct3 != 3'b000);
        rs1_used      = (funct3 != 3'b000) & ~funct3[2];
      end
      MISC_MEM: ;
      default: dec.illegal = 1'b1;
    endcase
    dec.regwr = wr & (rd != 5'd0);
  end

  // A writeback retiring the pending source this very cycle resolves the hazard via the bypass.
  assign rs1_pend = sb[rs1] & ~(regwr_en & (regwr_sel == rs1));
  assign rs2_pend = sb[rs2] & ~(regwr_en & (regwr_sel == rs2));
  assign stall    = pipe.pipe_in_vld & ((rs1_used & rs1_pend) | (rs2_used & rs2_pend));

  assign pipe.pipe_in_rdy  = ~stall & ~branch & (~out_vld | pipe.pipe_out_rdy);
  assign in_xfer           = pipe.pipe_in_vld & pipe.pipe_in_rdy;
  assign out_xfer          = out_vld & pipe.pipe_out_rdy;
  assign pipe.pipe_out_vld = out_vld;
  assign pipe.decode       = decode_q;

  // Set after clear so a newly issued writer keeps its bit while an older one retires.
  always_comb begin
    sb_next = sb;
    if (regwr_en) sb_next[regwr_sel] = 1'b0;
    if (in_xfer && dec.regwr) sb_next[dec.rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      out_vld <= 1'b0;
      sb      <= '0;
    end else begin
      sb <= sb_next;
      if (branch)        out_vld <= 1'b0;
      else if (in_xfer)  out_vld <= 1'b1;
      else if (out_xfer) out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) decode_q <= dec;
  end

endmodule

// File: tb/tb_kronos_id.sv
// Scenario bench for kronos_id: expected decode payloads are queued as instructions are
// offered and popped by a monitor whenever execute takes a payload.
module tb_kronos_id;
  import kronos_types::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] imm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [3:0]  aluop;
    logic        regwr;
    logic        illegal;
    logic        chk_data;
    logic        chk_rs2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstz;
  logic [31:0] regwr_data;
  logic [4:0]  regwr_sel;
  logic        regwr_en;
  logic        branch;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  kronos_id_if pipe ();

  kronos_id dut (
    .clk        (clk),
    .rstz       (rstz),
    .pipe       (pipe),
    .regwr_data (regwr_data),
    .regwr_sel  (regwr_sel),
    .regwr_en   (regwr_en),
    .branch     (branch)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ir, input logic [4:0] rd,
                              input logic [31:0] imm, input logic [31:0] op1, input logic [31:0] op2,
                              input logic [3:0] aluop, input logic regwr);
    exp_t e;
    e.pc = pc; e.ir = ir; e.rd = rd; e.imm = imm; e.op1 = op1; e.op2 = op2;
    e.aluop = aluop; e.regwr = regwr; e.illegal = 1'b0;
    e.rs2_data = '0; e.chk_data = 1'b1; e.chk_rs2 = 1'b0;
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstz && pipe.pipe_out_vld && pipe.pipe_out_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_output pc=%h ir=%h with empty queue", pipe.decode.pc, pipe.decode.ir);
        end else begin
          e = exp_q.pop_front();
          if ({pipe.decode.pc, pipe.decode.ir, pipe.decode.rd, pipe.decode.regwr, pipe.decode.illegal}
              !== {e.pc, e.ir, e.rd, e.regwr, e.illegal}) begin
            errors++;
            $display("[TB] FAIL payload got pc=%h ir=%h rd=%0d regwr=%b illegal=%b exp pc=%h ir=%h rd=%0d regwr=%b illegal=%b",
                     pipe.decode.pc, pipe.decode.ir, pipe.decode.rd, pipe.decode.regwr, pipe.decode.illegal,
                     e.pc, e.ir, e.rd, e.regwr, e.illegal);
          end
          if (e.chk_data) begin
            checks++;
            if ({pipe.decode.imm, pipe.decode.op1, pipe.decode.op2, pipe.decode.aluop}
                !== {e.imm, e.op1, e.op2, e.aluop}) begin
              errors++;
              $display("[TB] FAIL operands pc=%h got imm=%h op1=%h op2=%h aluop=%h exp imm=%h op1=%h op2=%h aluop=%h",
                       e.pc, pipe.decode.imm, pipe.decode.op1, pipe.decode.op2, pipe.decode.aluop,
                       e.imm, e.op1, e.op2, e.aluop);
            end
          end
          if (e.chk_rs2) begin
            checks++;
            if (pipe.decode.rs2_data !== e.rs2_data) begin
              errors++;
              $display("[TB] FAIL rs2_data pc=%h got %h exp %h", e.pc, pipe.decode.rs2_data, e.rs2_data);
            end
          end
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] ir, input exp_t e, output int waited);
    pipe.fetch       = {pc, ir};
    pipe.pipe_in_vld = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!pipe.pipe_in_rdy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!pipe.pipe_in_rdy) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout pc=%h ir=%h never accepted", pc, ir);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    pipe.pipe_in_vld = 1'b0;
  endtask

  task automatic writeback(input logic [4:0] sel, input logic [31:0] data);
    regwr_sel  = sel;
    regwr_data = data;
    regwr_en   = 1'b1;
    @(posedge clk); #1;
    regwr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rstz = 1'b0; branch = 1'b0; regwr_en = 1'b0; regwr_sel = '0; regwr_data = '0;
    pipe.pipe_in_vld = 1'b0; pipe.pipe_out_rdy = 1'b1; pipe.fetch = '0;
    #12;
    checks++;
    if ({pipe.pipe_out_vld, dut.sb, pipe.pipe_in_rdy} !== {1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_state got vld=%b sb=%h in_rdy=%b exp vld=0 sb=0 in_rdy=1",
               pipe.pipe_out_vld, dut.sb, pipe.pipe_in_rdy);
    end
    @(negedge clk); rstz = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    int w;
    send(32'h0, 32'h00500093, mk(32'h0, 32'h00500093, 5'd1, 32'd5, 32'd0, 32'd5, ALU_ADD, 1'b1), w);
    checks++;
    if ({pipe.pipe_out_vld, dut.sb[1]} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL addi_latency got vld=%b sb1=%b exp vld=1 sb1=1", pipe.pipe_out_vld, dut.sb[1]);
    end
    writeback(5'd1, 32'd5);
  endtask

  task automatic test_raw_stall();
    int w;
    int bad = 0;
    send(32'h10, 32'h00500093, mk(32'h10, 32'h00500093, 5'd1, 32'd5, 32'd0, 32'd5, ALU_ADD, 1'b1), w);
    pipe.fetch = {32'h14, 32'h00108133};
    pipe.pipe_in_vld = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (pipe.pipe_in_rdy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL raw_stall in_rdy high in %0d of 3 cycles, exp 0", bad);
    end
    @(posedge clk); #1;
    regwr_sel = 5'd1; regwr_data = 32'd7; regwr_en = 1'b1;
    exp_q.push_back(mk(32'h14, 32'h00108133, 5'd2, 32'd0, 32'd7, 32'd7, ALU_ADD, 1'b1));
    @(negedge clk);
    checks++;
    if (pipe.pipe_in_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL raw_release got in_rdy=%b exp 1", pipe.pipe_in_rdy);
    end
    @(posedge clk); #1;
    pipe.pipe_in_vld = 1'b0;
    regwr_en = 1'b0;
    checks++;
    if ({dut.sb[2], dut.sb[1]} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL raw_sb got sb2=%b sb1=%b exp sb2=1 sb1=0", dut.sb[2], dut.sb[1]);
    end
  endtask

  task automatic test_sb_collision();
    int w;
    writeback(5'd2, 32'd14);
    regwr_sel = 5'd2; regwr_data = 32'd15; regwr_en = 1'b1;
    send(32'h18, 32'h00900113, mk(32'h18, 32'h00900113, 5'd2, 32'd9, 32'd0, 32'd9, ALU_ADD, 1'b1), w);
    regwr_en = 1'b0;
    checks++;
    if (dut.sb[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_set_wins got sb2=%b exp 1", dut.sb[2]);
    end
    writeback(5'd2, 32'd9);
  endtask

  task automatic test_backpressure();
    int w;
    int bad = 0;
    pipe.pipe_out_rdy = 1'b0;
    send(32'h20, 32'h00100213, mk(32'h20, 32'h00100213, 5'd4, 32'd1, 32'd0, 32'd1, ALU_ADD, 1'b1), w);
    pipe.fetch = {32'h24, 32'h00200293};
    pipe.pipe_in_vld = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (pipe.pipe_in_rdy !== 1'b0 || pipe.pipe_out_vld !== 1'b1 ||
          pipe.decode.pc !== 32'h20 || pipe.decode.ir !== 32'h00100213) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL hold_stable %0d of 3 stalled cycles lost the held payload or raised in_rdy", bad);
    end
    @(posedge clk); #1;
    pipe.pipe_out_rdy = 1'b1;
    exp_q.push_back(mk(32'h24, 32'h00200293, 5'd5, 32'd2, 32'd0, 32'd2, ALU_ADD, 1'b1));
    @(negedge clk);
    checks++;
    if (pipe.pipe_in_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_release got in_rdy=%b exp 1", pipe.pipe_in_rdy);
    end
    @(posedge clk); #1;
    pipe.pipe_in_vld = 1'b0;
    checks++;
    if ({pipe.pipe_out_vld, pipe.decode.pc} !== {1'b1, 32'h24}) begin
      errors++;
      $display("[TB] FAIL hold_next got vld=%b pc=%h exp vld=1 pc=00000024", pipe.pipe_out_vld, pipe.decode.pc);
    end
  endtask

  task automatic test_flush();
    int w;
    repeat (2) begin @(posedge clk); #1; end
    pipe.pipe_out_rdy = 1'b0;
    send(32'h30, 32'h00300313, mk(32'h30, 32'h00300313, 5'd6, 32'd3, 32'd0, 32'd3, ALU_ADD, 1'b1), w);
    pipe.fetch = {32'h34, 32'h00400393};
    pipe.pipe_in_vld = 1'b1;
    branch = 1'b1;
    @(negedge clk);
    checks++;
    if (pipe.pipe_in_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_rdy got in_rdy=%b exp 0", pipe.pipe_in_rdy);
    end
    @(posedge clk); #1;
    branch = 1'b0;
    pipe.pipe_in_vld = 1'b0;
    checks++;
    if ({pipe.pipe_out_vld, dut.sb} !== {1'b0, 32'h00000070}) begin
      errors++;
      $display("[TB] FAIL flush_state got vld=%b sb=%h exp vld=0 sb=00000070", pipe.pipe_out_vld, dut.sb);
    end
    void'(exp_q.pop_back());
    pipe.pipe_out_rdy = 1'b1;
  endtask

  task automatic test_lui_jal_illegal();
    int w;
    exp_t e;
    send(32'h40, 32'h123452B7, mk(32'h40, 32'h123452B7, 5'd5, 32'h12345000, 32'd0, 32'h12345000, ALU_ADD, 1'b1), w);
    send(32'h44, 32'h0080006F, mk(32'h44, 32'h0080006F, 5'd0, 32'd8, 32'h44, 32'd8, ALU_ADD, 1'b0), w);
    checks++;
    if (dut.sb !== 32'h00000070) begin
      errors++;
      $display("[TB] FAIL jal_x0_sb got sb=%h exp 00000070", dut.sb);
    end
    e = mk(32'h48, 32'hFFFFFFFF, 5'd31, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0);
    e.illegal  = 1'b1;
    e.chk_data = 1'b0;
    send(32'h48, 32'hFFFFFFFF, e, w);
    checks++;
    if (dut.sb !== 32'h00000070) begin
      errors++;
      $display("[TB] FAIL illegal_sb got sb=%h exp 00000070", dut.sb);
    end
  endtask

  task automatic test_x0_write();
    int w;
    writeback(5'd0, 32'hDEADBEEF);
    send(32'h50, 32'h000001B3, mk(32'h50, 32'h000001B3, 5'd3, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b1), w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("[TB] FAIL x0_no_stall got %0d wait cycles exp 0", w);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    writeback(5'd5, 32'h55);
    pipe.pipe_out_rdy = 1'b0;
    send(32'h60, 32'h00500093, mk(32'h60, 32'h00500093, 5'd1, 32'd5, 32'd0, 32'd5, ALU_ADD, 1'b1), w);
    @(negedge clk); #2;
    rstz = 1'b0;
    #1;
    checks++;
    if ({pipe.pipe_out_vld, dut.sb} !== {1'b0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL async_reset got vld=%b sb=%h exp vld=0 sb=0", pipe.pipe_out_vld, dut.sb);
    end
    exp_q.delete();
    @(negedge clk);
    rstz = 1'b1;
    pipe.pipe_out_rdy = 1'b1;
    @(posedge clk); #1;
    send(32'h64, 32'h00128333, mk(32'h64, 32'h00128333, 5'd6, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b1), w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("[TB] FAIL reset_sb_discard got %0d wait cycles exp 0", w);
    end
  endtask

  task automatic test_alu_patterns();
    int w;
    exp_t e;
    writeback(5'd10, 32'd100);
    writeback(5'd11, 32'hFFFFFFFD);
    send(32'h70, 32'h40B50633, mk(32'h70, 32'h40B50633, 5'd12, 32'd0, 32'd100, 32'hFFFFFFFD, ALU_SUB, 1'b1), w);
    send(32'h74, 32'h4045D693, mk(32'h74, 32'h4045D693, 5'd13, 32'h404, 32'hFFFFFFFD, 32'h404, ALU_SRA, 1'b1), w);
    send(32'h78, 32'hFFF50713, mk(32'h78, 32'hFFF50713, 5'd14, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFFF, ALU_ADD, 1'b1), w);
    send(32'h7C, 32'hFEB50CE3, mk(32'h7C, 32'hFEB50CE3, 5'd25, 32'hFFFFFFF8, 32'd100, 32'hFFFFFFFD, ALU_ADD, 1'b0), w);
    e = mk(32'h80, 32'h00B52623, 5'd12, 32'd12, 32'd100, 32'd12, ALU_ADD, 1'b0);
    e.chk_rs2  = 1'b1;
    e.rs2_data = 32'hFFFFFFFD;
    send(32'h80, 32'h00B52623, e, w);
    checks++;
    if (dut.sb !== 32'h00007040) begin
      errors++;
      $display("[TB] FAIL alu_sb got sb=%h exp 00007040", dut.sb);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_addi();
    test_raw_stall();
    test_sb_collision();
    test_backpressure();
    test_flush();
    test_lui_jal_illegal();
    test_x0_write();
    test_reset_mid();
    test_alu_patterns();
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d undelivered payloads exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
